memory_interface: RTL and testbench
===================================

// Module: memory_interface
// PURPOSE
//  CPU-side bus master that moves one DATA_WIDTH word to/from a narrow external bus.
//  Splits each access into DATA_WIDTH/DATA_BUS_WIDTH byte phases with programmable wait
//  states, and drives address, mio, readRequest and a tri-state data bus.
//  Sits between the CPU pipeline (fetch/load/store) and the Memory/I/O bus.
// PARAMETERS
//  ADDRESS_BUS_WIDTH   32  address width (internal and bus)
//  DATA_WIDTH          32  word width seen by CPU
//  DATA_BUS_WIDTH       8  external bus width; DATA_WIDTH must be a multiple
//  CLOCK_COUNT_WIDTH    3  width of clockCount
// PORTS
//  clock        in   1    single clock; all state changes on rising edge
//  reset        in   1    asynchronous, active-low reset
//  enable       in   1    start request; sampled only while idle
//  readWrite    in   1    1 = read, 0 = write
//  isMemory     in   1    1 = memory space, 0 = I/O space
//  address      in   ADDRESS_BUS_WIDTH   word start address
//  dataIn       in   DATA_WIDTH          write data
//  clockCount   in   CLOCK_COUNT_WIDTH   wait states per byte phase
//  dataOut      out  DATA_WIDTH          read result
//  ready        out  1    access complete
//  addressBus   out  ADDRESS_BUS_WIDTH   byte address on bus
//  dataBus      inout DATA_BUS_WIDTH     byte data; driven only on writes
//  mio          out  1    bus space select; 1 = memory
//  readRequest  out  1    bus read strobe
// BEHAVIOUR
//  - Reset (async, low): state IDLE; ready=0, dataOut=0, addressBus=0, mio=0,
//    readRequest=0, dataBus=Z. Reset mid-access aborts it: no ready, no dataOut update.
//  - FSM: IDLE -> BUSY -> DONE.
//    IDLE/DONE + enable=1 at an edge: latch address, dataIn, readWrite, isMemory and
//    clockCount; byte index=0; ready<=0; go BUSY. enable while BUSY is ignored.
//  - Phase length L = clockCount+1 cycles; clockCount=0 is treated as 1, so L>=2.
//  - BUSY, byte k (0..N-1, N=DATA_WIDTH/DATA_BUS_WIDTH), little-endian:
//    addressBus = latched address + k.
//    mio = latched isMemory.
//    readRequest = latched readWrite.
//    Write: dataBus = word[8k+7:8k]. Read: dataBus = Z.
//  - Last edge of each phase:
//    Read: capture dataBus into byte k of dataOut.
//    Write: the target latches the byte on this edge.
//    Then k increments.
//  - After byte N-1: go DONE, ready=1, bus outputs return to idle values
//    (mio=0, readRequest=0, dataBus=Z).
//  - ready stays 1 in DONE until the next enable is accepted.
//  - dataOut is held until the next read completes; writes do not alter it.
//  - Latency: ready rises N*L cycles after the accepting edge (clockCount=1 -> 8 cycles).
//  - Targets respond to mio=1 (memory) or mio=0 (I/O) only while readRequest or the
//    dataBus drive is active. Bus outputs are registered (glitch-free).
// TESTING
//  1. Reset low then high; write 1 to addr 0, clockCount=1 ->
//     bytes 01,00,00,00 at addr 0..3, mio=1, readRequest=0; ready=1 after 8 cycles.
//  2. Write 2 to addr 4 -> bytes 02,00,00,00 at addr 4..7; ready after 8 cycles.
//  3. Read addr 0 -> readRequest=1, dataBus Z from master; dataOut=32'h1, ready=1.
//  4. Read addr 4 -> dataOut=32'h2; enable pulsed while BUSY -> no restart, same latency.
//  5. clockCount=3, read addr 0 -> each address held 4 cycles; ready after 16 cycles;
//     clockCount=0 -> behaves as 1.
//  6. Assert reset mid-read -> ready=0, dataOut=0, mio=0, readRequest=0, dataBus=Z
//     immediately; next access works normally.

Source files
------------

// File: rtl/memory_interface_if.sv
// CPU-side request/response bundle for memory_interface.
// The CPU pipeline holds the master modport; the bus controller takes the slave view.
interface memory_interface_if #(
    parameter int ADDRESS_BUS_WIDTH = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int CLOCK_COUNT_WIDTH = 3
);
    logic                         enable;
    logic                         readWrite;
    logic                         isMemory;
    logic [ADDRESS_BUS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]        dataIn;
    logic [CLOCK_COUNT_WIDTH-1:0] clockCount;
    logic [DATA_WIDTH-1:0]        dataOut;
    logic                         ready;

    modport master (
        output enable, readWrite, isMemory, address, dataIn, clockCount,
        input  dataOut, ready
    );

    modport slave (
        input  enable, readWrite, isMemory, address, dataIn, clockCount,
        output dataOut, ready
    );
endinterface

// File: rtl/memory_interface.sv
// Narrow-bus master: splits one CPU word access into little-endian byte phases
// with programmable wait states on a registered, tri-stated external bus.
//
// state | meaning
// IDLE  | no access since reset; bus idle, waiting for enable
// BUSY  | stepping byte phases; bus driven for the current byte
// DONE  | access finished; ready held high until the next enable
module memory_interface #(
    parameter int ADDRESS_BUS_WIDTH = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int DATA_BUS_WIDTH    = 8,
    parameter int CLOCK_COUNT_WIDTH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    memory_interface_if.slave            cpu,
    output logic [ADDRESS_BUS_WIDTH-1:0] addressBus,
    inout  wire  [DATA_BUS_WIDTH-1:0]    dataBus,
    output logic                         mio,
    output logic                         readRequest
);
    localparam int BYTE_COUNT = DATA_WIDTH / DATA_BUS_WIDTH;
    localparam int IDX_WIDTH  = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateType;

    stateType                     state;
    logic [ADDRESS_BUS_WIDTH-1:0] addrLatch;
    logic [DATA_WIDTH-1:0]        wordLatch;
    logic [CLOCK_COUNT_WIDTH-1:0] phaseLoad;
    logic [CLOCK_COUNT_WIDTH-1:0] phaseCnt;
    logic [IDX_WIDTH-1:0]         byteIdx;
    logic [DATA_WIDTH-1:0]        dataOutReg;
    logic                         readyReg;
    logic                         busDrive;
    logic [DATA_BUS_WIDTH-1:0]    busByte;

    logic [IDX_WIDTH-1:0]         nextIdx;
    logic [CLOCK_COUNT_WIDTH-1:0] effCount;
    logic                         lastByte;

    assign nextIdx  = byteIdx + 1'b1;
    assign lastByte = (int'(byteIdx) == BYTE_COUNT - 1);
    // A zero wait count still needs one settle cycle before the strobe edge.
    assign effCount = (cpu.clockCount == '0) ? CLOCK_COUNT_WIDTH'(1) : cpu.clockCount;

    assign dataBus     = busDrive ? busByte : 'z;
    assign cpu.dataOut = dataOutReg;
    assign cpu.ready   = readyReg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            addrLatch   <= '0;
            wordLatch   <= '0;
            phaseLoad   <= '0;
            phaseCnt    <= '0;
            byteIdx     <= '0;
            dataOutReg  <= '0;
            readyReg    <= 1'b0;
            addressBus  <= '0;
            mio         <= 1'b0;
            readRequest <= 1'b0;
            busDrive    <= 1'b0;
            busByte     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (cpu.enable) begin
                        addrLatch   <= cpu.address;
                        wordLatch   <= cpu.dataIn;
                        phaseLoad   <= effCount;
                        phaseCnt    <= effCount;
                        byteIdx     <= '0;
                        readyReg    <= 1'b0;
                        addressBus  <= cpu.address;
                        mio         <= cpu.isMemory;
                        readRequest <= cpu.readWrite;
                        busDrive    <= !cpu.readWrite;
                        busByte     <= cpu.dataIn[DATA_BUS_WIDTH-1:0];
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (phaseCnt == '0) begin
                        // Terminal count: this edge is the strobe edge of the phase.
                        if (readRequest) begin
                            dataOutReg[int'(byteIdx)*DATA_BUS_WIDTH +: DATA_BUS_WIDTH] <= dataBus;
                        end
                        if (lastByte) begin
                            state       <= DONE;
                            readyReg    <= 1'b1;
                            mio         <= 1'b0;
                            readRequest <= 1'b0;
                            busDrive    <= 1'b0;
                        end else begin
                            byteIdx    <= nextIdx;
                            phaseCnt   <= phaseLoad;
                            addressBus <= addrLatch + ADDRESS_BUS_WIDTH'(nextIdx);
                            busByte    <= wordLatch[int'(nextIdx)*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
                        end
                    end else begin
                        phaseCnt <= phaseCnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface: a small byte-memory target on the bus,
// per-cycle bus checks against hand-derived expectations.
module tb_memory_interface;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addressBus;
    wire  [7:0]  dataBus;
    logic        mio;
    logic        readRequest;

    logic [7:0]  mem [16];
    logic        probeOn = 1'b0;
    logic        tgtEn;
    logic [7:0]  tgtByte;
    logic [31:0] expDataOut = 32'h0;
    int          compared = 0;
    int          mismatched = 0;

    memory_interface_if cpu ();

    memory_interface dut (
        .clock      (clock),
        .reset      (reset),
        .cpu        (cpu),
        .addressBus (addressBus),
        .dataBus    (dataBus),
        .mio        (mio),
        .readRequest(readRequest)
    );

    always #5 clock = ~clock;

    // Memory target answers reads; the probe drives 00 to confirm the master is off the bus.
    assign tgtEn   = (readRequest && mio) || probeOn;
    assign tgtByte = readRequest ? mem[addressBus[3:0]] : 8'h00;
    assign dataBus = tgtEn ? tgtByte : 8'bz;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic probeIdle(input string tag);
        probeOn = 1'b1;
        #1;
        checkVal(tag, {24'h0, dataBus}, 32'h0);
        probeOn = 1'b0;
    endtask

    task automatic runAccess(input string tag, input logic rw, input logic isMem,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] cc, input bit pulseMid,
                             input logic [31:0] expRead);
        int phaseLen;
        int total;
        int k;
        phaseLen = (cc == 3'd0) ? 2 : int'(cc) + 1;
        total    = 4 * phaseLen;
        @(negedge clock);
        cpu.enable     = 1'b1;
        cpu.readWrite  = rw;
        cpu.isMemory   = isMem;
        cpu.address    = addr;
        cpu.dataIn     = wdata;
        cpu.clockCount = cc;
        @(negedge clock);
        cpu.enable = 1'b0;
        for (int j = 0; j < total; j++) begin
            k = j / phaseLen;
            if (pulseMid && j == 2) cpu.enable = 1'b1;
            if (pulseMid && j == 3) cpu.enable = 1'b0;
            checkVal($sformatf("%s.addr%0d", tag, j), addressBus, addr + 32'(k));
            checkVal($sformatf("%s.mio%0d", tag, j), {31'h0, mio}, {31'h0, isMem});
            checkVal($sformatf("%s.rreq%0d", tag, j), {31'h0, readRequest}, {31'h0, rw});
            checkVal($sformatf("%s.rdy%0d", tag, j), {31'h0, cpu.ready}, 32'h0);
            if (rw) begin
                checkVal($sformatf("%s.rbyte%0d", tag, j), {24'h0, dataBus}, {24'h0, expRead[8*k +: 8]});
            end else begin
                checkVal($sformatf("%s.wbyte%0d", tag, j), {24'h0, dataBus}, {24'h0, wdata[8*k +: 8]});
                if (mio) mem[addressBus[3:0]] = dataBus;
            end
            if (j < total - 1) @(negedge clock);
        end
        @(negedge clock);
        if (rw) expDataOut = expRead;
        checkVal({tag, ".ready"}, {31'h0, cpu.ready}, 32'h1);
        checkVal({tag, ".mioIdle"}, {31'h0, mio}, 32'h0);
        checkVal({tag, ".rreqIdle"}, {31'h0, readRequest}, 32'h0);
        checkVal({tag, ".dataOut"}, cpu.dataOut, expDataOut);
        probeIdle({tag, ".busZ"});
        @(negedge clock);
        checkVal({tag, ".readyHold"}, {31'h0, cpu.ready}, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        cpu.enable     = 1'b0;
        cpu.readWrite  = 1'b0;
        cpu.isMemory   = 1'b0;
        cpu.address    = 32'h0;
        cpu.dataIn     = 32'h0;
        cpu.clockCount = 3'd0;

        repeat (2) @(negedge clock);
        checkVal("rst.ready", {31'h0, cpu.ready}, 32'h0);
        checkVal("rst.dataOut", cpu.dataOut, 32'h0);
        checkVal("rst.addr", addressBus, 32'h0);
        checkVal("rst.mio", {31'h0, mio}, 32'h0);
        checkVal("rst.rreq", {31'h0, readRequest}, 32'h0);
        probeIdle("rst.busZ");
        reset = 1'b1;
        @(negedge clock);
        checkVal("idle.ready", {31'h0, cpu.ready}, 32'h0);

        runAccess("wr1", 1'b0, 1'b1, 32'h0, 32'h0000_0001, 3'd1, 1'b0, 32'h0);
        runAccess("wr2", 1'b0, 1'b1, 32'h4, 32'h0000_0002, 3'd1, 1'b0, 32'h0);
        runAccess("rd0", 1'b1, 1'b1, 32'h0, 32'h0, 3'd1, 1'b0, 32'h0000_0001);
        runAccess("rd4p", 1'b1, 1'b1, 32'h4, 32'h0, 3'd1, 1'b1, 32'h0000_0002);
        runAccess("wrIo", 1'b0, 1'b0, 32'h8, 32'hA5B6_C7D8, 3'd2, 1'b0, 32'h0);
        runAccess("wrMem", 1'b0, 1'b1, 32'h8, 32'h1122_3344, 3'd1, 1'b0, 32'h0);
        runAccess("rd0cc3", 1'b1, 1'b1, 32'h0, 32'h0, 3'd3, 1'b0, 32'h0000_0001);
        runAccess("rd8cc0", 1'b1, 1'b1, 32'h8, 32'h0, 3'd0, 1'b0, 32'h1122_3344);

        // Abort a read part-way through with an asynchronous reset.
        @(negedge clock);
        cpu.enable     = 1'b1;
        cpu.readWrite  = 1'b1;
        cpu.isMemory   = 1'b1;
        cpu.address    = 32'h4;
        cpu.clockCount = 3'd1;
        @(negedge clock);
        cpu.enable = 1'b0;
        repeat (3) @(negedge clock);
        checkVal("abort.rreqBefore", {31'h0, readRequest}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        checkVal("abort.ready", {31'h0, cpu.ready}, 32'h0);
        checkVal("abort.dataOut", cpu.dataOut, 32'h0);
        checkVal("abort.mio", {31'h0, mio}, 32'h0);
        checkVal("abort.rreq", {31'h0, readRequest}, 32'h0);
        probeIdle("abort.busZ");
        expDataOut = 32'h0;
        @(negedge clock);
        reset = 1'b1;
        runAccess("postRst", 1'b1, 1'b1, 32'h4, 32'h0, 3'd1, 1'b0, 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
